// File: rtl/psum_acc_int18_pkg.sv
// Shared definitions for the INT16 partial-sum accumulator and its helpers:
// default datapath widths and the control FSM state encoding.
package psum_acc_int18_pkg;

  localparam int PSUM_ACC_W    = 24;  // signed accumulator width
  localparam int PSUM_DATA18_W = 18;  // result width
  localparam int PSUM_DATA16_W = 16;  // partial-product width
  localparam int PSUM_LEN_W    = 8;   // window-length field width
  localparam int PSUM_SH_W     = 3;   // shift-amount field width

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } psum_state_e;

endpackage : psum_acc_int18_pkg

// File: rtl/psum_shift_round.sv
// Combinational scaling stage for accumulated sums: arithmetic right shift,
// optional round-half-up (macro PSUM_ROUND_EN), and detection of results
// that do not fit the narrow output width.
module psum_shift_round #(
  parameter int ACC_W = 24,
  parameter int SH_W  = 3,
  parameter int OUT_W = 18
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic        [SH_W-1:0]  sh_i,
  output logic        [OUT_W-1:0] data_o,
  output logic                    ovf_o
);

  // True when the bits above the output sign bit are not pure sign extension.
  function automatic logic not_sign_ext(input logic [ACC_W-OUT_W:0] top);
    return !((&top) || !(|top));
  endfunction

  logic signed [ACC_W-1:0] rnd_s;
  logic signed [ACC_W-1:0] biased_s;
  logic signed [ACC_W-1:0] shifted_s;

  // Optional rounding bias, then arithmetic shift and overflow detection.
  always_comb begin
    rnd_s = '0;
`ifdef PSUM_ROUND_EN
    if (sh_i != '0) begin
      rnd_s = ACC_W'(1) << (sh_i - SH_W'(1));
    end else begin
      rnd_s = '0;
    end
`endif
    biased_s  = sum_i + rnd_s;
    shifted_s = biased_s >>> sh_i;
    data_o    = shifted_s[OUT_W-1:0];
    ovf_o     = not_sign_ext(shifted_s[ACC_W-1:OUT_W-1]);
  end

endmodule : psum_shift_round

// File: rtl/psum_acc_int18.sv
// Windowed accumulator: sums a stream of signed INT16 partial products over
// cfg_len beats, scales by cfg_shift and emits one INT18 result per window
// through a single-entry output register with valid/ready handshaking.
// Optional feature macro: PSUM_ROUND_EN (round-half-up on the final shift).
module psum_acc_int18
  import psum_acc_int18_pkg::*;
#(
  parameter int ACC_W = PSUM_ACC_W,
  parameter int LEN_W = PSUM_LEN_W,
  parameter int SH_W  = PSUM_SH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [SH_W-1:0]  cfg_shift,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_data,
  output logic             out_ovf
);

  psum_state_e state_q, state_d;

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic [17:0] out_data_q, out_data_d;
  logic        out_ovf_q, out_ovf_d;

  logic                    in_ready_s;
  logic                    accept_s;
  logic                    first_s;
  logic                    last_s;
  logic [LEN_W-1:0]        len_eff_s;
  logic [LEN_W-1:0]        len_sel_s;
  logic [SH_W-1:0]         sh_sel_s;
  logic signed [ACC_W-1:0] in_ext_s;
  logic signed [ACC_W-1:0] final_s;
  logic [17:0]             res_data_s;
  logic                    res_ovf_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE one cycle after reset, then stay in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_ACCUM;
      ST_ACCUM: state_d = ST_ACCUM;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept beats only when accumulating and no result is stuck.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready_s = !(out_valid_q && !out_ready);
      ST_IDLE:  in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Beat datapath: on the first beat of a window the live cfg values apply,
  // afterwards the values latched on that first beat.
  always_comb begin
    accept_s  = in_valid && in_ready_s;
    first_s   = (cnt_q == '0);
    len_eff_s = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    len_sel_s = first_s ? len_eff_s : len_q;
    sh_sel_s  = first_s ? cfg_shift : sh_q;
    last_s    = (cnt_q == (len_sel_s - LEN_W'(1)));
    in_ext_s  = {{(ACC_W-16){in_data[15]}}, in_data};
    final_s   = (first_s ? '0 : acc_q) + in_ext_s;
  end

  psum_shift_round #(
    .ACC_W (ACC_W),
    .SH_W  (SH_W),
    .OUT_W (18)
  ) u_shift_round (
    .sum_i  (final_s),
    .sh_i   (sh_sel_s),
    .data_o (res_data_s),
    .ovf_o  (res_ovf_s)
  );

  // Next-state for counter, accumulator, latched config and output register.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (accept_s) begin
      if (first_s) begin
        len_d = len_eff_s;
        sh_d  = cfg_shift;
      end else begin
        len_d = len_q;
        sh_d  = sh_q;
      end
      if (last_s) begin
        cnt_d       = '0;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = res_data_s;
        out_ovf_d   = res_ovf_s;
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
        acc_d = final_s;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      sh_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 18'd0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule : psum_acc_int18

// File: tb/tb_psum_acc_int18.sv
// Directed self-checking bench for psum_acc_int18.
module tb_psum_acc_int18;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_len;
  logic [2:0]  cfg_shift;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  psum_acc_int18 dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for in_ready, return #1 after acceptance edge.
  task automatic send(input logic [15:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [17:0] d, input logic ovf);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {14'd0, out_data},  {14'd0, d});
    check({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_len   = 8'd0;
    cfg_shift = 3'd0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_data",  {14'd0, out_data},  32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("accum_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: 100+200-50 = 250, cfg changes mid-window ignored.
    cfg_len = 8'd3; cfg_shift = 3'd0;
    send(16'd100);
    cfg_len = 8'd1; cfg_shift = 3'd3;
    send(16'd200);
    check("t1_mid_valid", {31'd0, out_valid}, 32'd0);
    send(-16'sd50);
    expect_result("t1", 18'd250, 1'b0);

    // 2a: 4 x 32767 = 131068 fits.
    cfg_len = 8'd4; cfg_shift = 3'd0;
    for (int i = 0; i < 4; i++) send(16'd32767);
    expect_result("t2a", 18'h1FFFC, 1'b0);

    // 2b: 8 x 32767 = 262136 does not fit in INT18.
    cfg_len = 8'd8;
    for (int i = 0; i < 8; i++) send(16'd32767);
    expect_result("t2b", 18'h3FFF8, 1'b1);

    // 3: sum 7 and -7 shifted right by 2.
    cfg_len = 8'd2; cfg_shift = 3'd2;
    send(16'd5);
    send(16'd2);
`ifdef PSUM_ROUND_EN
    expect_result("t3_pos", 18'd2, 1'b0);
`else
    expect_result("t3_pos", 18'd1, 1'b0);
`endif
    send(-16'sd5);
    send(-16'sd2);
    expect_result("t3_neg", 18'h3FFFE, 1'b0);

    // 5: cfg_len 0 is a single-beat window.
    cfg_len = 8'd0; cfg_shift = 3'd0;
    send(16'd1234);
    expect_result("t5", 18'd1234, 1'b0);

    // 4: backpressure hold, then back-to-back acceptance on release.
    cfg_len = 8'd2; cfg_shift = 3'd0;
    send(16'd10);
    out_ready = 1'b0;
    send(16'd20);
    expect_result("t4", 18'd30, 1'b0);
    cfg_len  = 8'd1;
    in_data  = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_data",  {14'd0, out_data},  32'd30);
      check("t4_hold_ready", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_result("t4_b2b", 18'd7, 1'b0);
    @(posedge clk);
    #1;
    check("t4_consumed", {31'd0, out_valid}, 32'd0);

    // 6: reset mid-window discards the partial sum.
    cfg_len = 8'd4;
    send(16'd100);
    send(16'd100);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_ready", {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd1);
    expect_result("t6", 18'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_psum_acc_int18
